video_out_stream: RTL and testbench
===================================

// Module: video_out_stream
// PURPOSE
// - Parametrised successor to the video output generator.
// - Reads pixels from a first-word-fall-through FIFO, which the RAM reader fills.
// - Generates frame_valid, line_valid and pixel_out with programmable active and blanking timing,
//   multi-channel pixels and an internal pixel-rate divider.
// - Adds underflow detection and fill, a frame-done pulse, and a clean start/stop at frame boundaries.
// PARAMETERS
// - PIX_W         8    bits per channel
// - CHANNELS      1    channels per pixel; the data bus is CHANNELS*PIX_W bits
// - H_ACT         640  active pixels per line (>=1)
// - H_BLANK       160  blanking pixel ticks per line (>=1)
// - V_ACT         480  active lines per frame (>=1)
// - V_BLANK       45   blanking lines per frame (>=1)
// - CLK_DIV       4    clk cycles per pixel tick (>=1; 1 = every cycle)
// - UNDERFLOW_PIX 0    value driven on every channel when the FIFO is empty during an active tick
// PORTS
// - clk            in   1                 system clock; the only clock
// - RST            in   1                 synchronous, active-high reset
// - enable         in   1                 run request; sampled only in IDLE and at frame end
// - fifo_data      in   CHANNELS*PIX_W    FIFO head word; valid whenever !fifo_empty
// - fifo_empty     in   1                 FIFO empty flag
// - fifo_rd        out  1                 pop strobe; one clk wide
// - underflow_clr  in   1                 clears the sticky underflow flag
// - pixel_out      out  CHANNELS*PIX_W    registered pixel
// - line_valid     out  1                 high during active pixels
// - frame_valid    out  1                 high from the first active pixel to the end of the last active line's blank
// - frame_done     out  1                 one-clk pulse on frame_valid fall
// - underflow      out  1                 sticky: at least one pixel was filled since the last clear
// BEHAVIOUR
// - Reset: all outputs 0.
//   - State IDLE; the tick divider and h/v counters are cleared.
//   - Reset mid-frame aborts the frame immediately and emits no frame_done.
// - Pixel tick:
//   - The divider counts 0..CLK_DIV-1 and asserts tick when the count is 0.
//   - The counter is held at 0 in IDLE and WAIT, so the first tick falls on the clk after leaving WAIT.
// - FSM IDLE -> WAIT: when enable=1.
// - FSM WAIT -> ACTIVE: when !fifo_empty, to prevent underflow on pixel 0.
// - FSM ACTIVE -> HBLANK: after H_ACT ticks.
// - FSM HBLANK:
//   - After H_BLANK ticks, go to ACTIVE if the active line count is < V_ACT.
//   - Otherwise go to VBLANK.
// - FSM VBLANK -> (enable ? WAIT : IDLE): after V_BLANK*(H_ACT+H_BLANK) ticks.
// - Active tick:
//   - Register pixel_out and assert line_valid and frame_valid together; output latency is 1 clk from the tick.
//   - fifo_rd=1 for that same clk if !fifo_empty; pixel_out<=fifo_data.
//   - If the FIFO is empty: no pop, pixel_out<=UNDERFLOW_PIX replicated, underflow<=1.
// - line_valid:
//   - Held high for exactly H_ACT*CLK_DIV clks per line.
//   - Drops on the first HBLANK tick.
//   - pixel_out returns to 0 when line_valid=0.
// - frame_valid:
//   - Rises with the first line_valid of the frame.
//   - Falls on the clk the last HBLANK ends.
//   - frame_done pulses in that same clk.
// - Stop: deasserting enable mid-frame does not truncate.
//   - The frame and its VBLANK complete, then the FSM returns to IDLE.
//   - A re-assert before VBLANK ends continues seamlessly.
// - underflow: if underflow_clr and a new underflow occur in the same clk, the set wins.
// - fifo_rd is never asserted outside ACTIVE ticks and never while fifo_empty=1.
// - Widths:
//   - h counter $clog2(H_ACT+H_BLANK).
//   - v counter $clog2(V_ACT+V_BLANK).
//   - Divider counter $clog2(CLK_DIV), minimum 1 bit.
//   - All counters wrap only by explicit FSM reload, never by overflow.
// STRUCTURE
// - video_pkg:
//   - vo_state_t enum (IDLE, WAIT, ACTIVE, HBLANK, VBLANK).
//   - Timing localparam helpers (LINE_TICKS, FRAME_LINES).
//   - Function to replicate UNDERFLOW_PIX across channels.
// - Sub-module video_tick_div: CLK_DIV divider with synchronous clear; outputs tick.
// - Top: FSM, h/v counters, output registers, underflow flag.
// TESTING (bench params: PIX_W=8, CHANNELS=2, H_ACT=4, H_BLANK=2, V_ACT=3, V_BLANK=1, CLK_DIV=1 unless noted)
// - Nominal frame:
//   - Stimulus: FIFO pre-loaded with 12 words 0x0100..0x010B; enable=1.
//   - Required response: 3 lines of 4 line_valid clks with 2-clk gaps; pixel_out sequence matches the words.
//   - frame_valid high 18 clks; one frame_done pulse; 12 fifo_rd pulses; underflow=0.
// - Underflow:
//   - Stimulus: FIFO holds 5 words.
//   - Required response: pixels 6..12 = 0x0000; no fifo_rd while empty.
//   - Required response: underflow=1 until underflow_clr; a clear during a new underflow keeps it at 1.
// - Divider:
//   - Stimulus: CLK_DIV=4.
//   - Required response: each pixel held 4 clks; line_valid 16 clks; fifo_rd pulses exactly 4 clks apart, each 1 clk wide.
// - Stop at boundary:
//   - Stimulus: drop enable during line 2.
//   - Required response: the frame completes; after VBLANK (6 clks) the FSM is in IDLE with all outputs 0; no second frame.
// - Reset mid-line:
//   - Stimulus: RST=1 for 1 clk during pixel 2 of line 1.
//   - Required response: next clk all outputs 0, no frame_done.
//   - Required response: the restart waits in WAIT until !fifo_empty.
// - Back-to-back frames:
//   - Stimulus: enable held high with the FIFO kept non-empty.
//   - Required response: frame 2 starts after VBLANK plus 1 WAIT clk; exactly 2 frame_done pulses over 2 frames.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: FSM states, timing helpers and underflow fill replication for video_out_stream
package video_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, ACTIVE, HBLANK, VBLANK} vo_state_t;
  localparam int MAX_W = 256;
  function automatic int line_ticks(input int h_act, input int h_blank);
    return h_act + h_blank;
  endfunction
  function automatic int frame_lines(input int v_act, input int v_blank);
    return v_act + v_blank;
  endfunction
  function automatic logic [MAX_W-1:0] fill_word(input logic [MAX_W-1:0] pix, input int pix_w, input int channels);
    logic [MAX_W-1:0] mask, w;
    mask = (MAX_W'(1) << pix_w) - MAX_W'(1);
    w = '0;
    for (int c = 0; c < channels; c++) w = w | ((pix & mask) << (c * pix_w));
    return w;
  endfunction
endpackage

// File: rtl/video_tick_div.sv
// video_tick_div: pixel tick divider, tick high when the count is 0, held at 0 by clr
module video_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/video_out_stream.sv
// video_out_stream: FIFO-fed video timing generator with blanking, pixel divider and underflow fill
module video_out_stream
  import video_pkg::*;
#(
  parameter int PIX_W         = 8,
  parameter int CHANNELS      = 1,
  parameter int H_ACT         = 640,
  parameter int H_BLANK       = 160,
  parameter int V_ACT         = 480,
  parameter int V_BLANK       = 45,
  parameter int CLK_DIV       = 4,
  parameter int UNDERFLOW_PIX = 0
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [CHANNELS*PIX_W-1:0] fifo_data,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  input  logic                      underflow_clr,
  output logic [CHANNELS*PIX_W-1:0] pixel_out,
  output logic                      line_valid,
  output logic                      frame_valid,
  output logic                      frame_done,
  output logic                      underflow
);
  localparam int DW = CHANNELS * PIX_W;
  localparam int LT = line_ticks(H_ACT, H_BLANK);
  localparam int HW = $clog2(LT);
  localparam int VW = $clog2(frame_lines(V_ACT, V_BLANK));
  localparam logic [MAX_W-1:0] FILL_ALL = fill_word(MAX_W'(UNDERFLOW_PIX), PIX_W, CHANNELS);
  localparam logic [DW-1:0] FILL = FILL_ALL[DW-1:0];
  vo_state_t state, state_n;
  logic [HW-1:0] h, h_n;
  logic [VW-1:0] v, v_n;
  logic tick, act_tick;
  assign act_tick = tick && state == ACTIVE;
  assign fifo_rd = act_tick && !fifo_empty && !RST;
  video_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (RST),
    .clr (state == IDLE || state == WAIT),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    h_n = h;
    v_n = v;
    case (state)
      IDLE: state_n = enable ? WAIT : IDLE;
      WAIT: state_n = fifo_empty ? WAIT : ACTIVE;
      ACTIVE: if (tick) begin
        h_n = (h == HW'(H_ACT - 1)) ? '0 : h + 1'b1;
        state_n = (h == HW'(H_ACT - 1)) ? HBLANK : ACTIVE;
      end
      HBLANK: if (tick) begin
        if (h == HW'(H_BLANK - 1)) begin
          h_n = '0;
          v_n = (v == VW'(V_ACT - 1)) ? '0 : v + 1'b1;
          state_n = (v == VW'(V_ACT - 1)) ? VBLANK : ACTIVE;
        end else h_n = h + 1'b1;
      end
      VBLANK: if (tick) begin
        if (h == HW'(LT - 1)) begin
          h_n = '0;
          v_n = (v == VW'(V_BLANK - 1)) ? '0 : v + 1'b1;
          if (v == VW'(V_BLANK - 1)) state_n = enable ? WAIT : IDLE;
        end else h_n = h + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      h <= '0;
      v <= '0;
      pixel_out <= '0;
      line_valid <= 1'b0;
      frame_valid <= 1'b0;
      frame_done <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      h <= h_n;
      v <= v_n;
      frame_done <= tick && frame_valid && state == VBLANK;
      if (tick) begin
        line_valid <= state == ACTIVE;
        frame_valid <= state == ACTIVE || state == HBLANK;
        pixel_out <= (state != ACTIVE) ? '0 : (fifo_empty ? FILL : fifo_data);
      end
      underflow <= (act_tick && fifo_empty) || (underflow && !underflow_clr);
    end
  end
endmodule

// File: tb/tb_video_out_stream.sv
// tb_video_out_stream: scoreboard bench for video_out_stream at CLK_DIV=1 and CLK_DIV=4
module tb_video_out_stream;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic en_a = 0, clr_a = 0, rd_a, lv_a, fv_a, fd_a, uf_a, empty_a;
  logic [15:0] data_a, pix_a;
  logic [15:0] mem [0:63];
  int wr_p = 0, rd_p = 0;
  assign empty_a = (wr_p == rd_p);
  assign data_a = mem[rd_p[5:0]];
  always @(posedge clk) if (rd_a) rd_p <= rd_p + 1;
  logic en_b = 0, clr_b = 0, go_b = 0, rd_b, lv_b, fv_b, fd_b, uf_b, empty_b;
  logic [15:0] data_b, pix_b;
  int cnt_b = 0;
  assign empty_b = !go_b;
  assign data_b = {8'h03, cnt_b[7:0]};
  always @(posedge clk) if (rd_b) cnt_b <= cnt_b + 1;
  video_out_stream #(.PIX_W(8), .CHANNELS(2), .H_ACT(4), .H_BLANK(2), .V_ACT(3), .V_BLANK(1), .CLK_DIV(1)) dut_a (
    .clk(clk), .RST(rst), .enable(en_a), .fifo_data(data_a), .fifo_empty(empty_a), .fifo_rd(rd_a),
    .underflow_clr(clr_a), .pixel_out(pix_a), .line_valid(lv_a), .frame_valid(fv_a), .frame_done(fd_a), .underflow(uf_a)
  );
  video_out_stream #(.PIX_W(8), .CHANNELS(2), .H_ACT(4), .H_BLANK(2), .V_ACT(3), .V_BLANK(1), .CLK_DIV(4)) dut_b (
    .clk(clk), .RST(rst), .enable(en_b), .fifo_data(data_b), .fifo_empty(empty_b), .fifo_rd(rd_b),
    .underflow_clr(clr_b), .pixel_out(pix_b), .line_valid(lv_b), .frame_valid(fv_b), .frame_done(fd_b), .underflow(uf_b)
  );
  logic [31:0] exp_q[$], exp_b[$];
  int rises[$], runs[$];
  int n_lv, n_fv, n_fd, n_rd, cur_run;
  logic prev_lv = 0, prev_fv = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic clr_counts();
    n_lv = 0; n_fv = 0; n_fd = 0; n_rd = 0; cur_run = 0;
    rises.delete();
    runs.delete();
  endtask
  task automatic push(input logic [15:0] w, input logic expected);
    mem[wr_p[5:0]] = w;
    wr_p++;
    if (expected) exp_q.push_back({16'h0, w});
  endtask
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (lv_a) begin
      n_lv++;
      if (!prev_lv) rises.push_back(cyc);
      cur_run = prev_lv ? cur_run + 1 : 1;
      e = 32'hDEAD_0000;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("pixel", {16'h0, pix_a}, e);
      chk("lv_in_fv", {31'h0, fv_a}, 1);
    end else begin
      if (prev_lv) runs.push_back(cur_run);
      chk("pix_blank", {16'h0, pix_a}, 0);
    end
    if (fv_a) n_fv++;
    if (fd_a) begin
      n_fd++;
      chk("fd_on_fall", {30'h0, prev_fv, fv_a}, 2);
    end
    if (rd_a) begin
      n_rd++;
      chk("rd_not_empty", {31'h0, empty_a}, 0);
    end
    prev_lv = lv_a;
    prev_fv = fv_a;
  endtask
  task automatic run_fd(input int target, input int bound);
    int k = 0;
    while (n_fd < target && k < bound) begin
      step();
      k++;
    end
    chk("fd_timeout", {31'h0, n_fd >= target}, 1);
  endtask
  task automatic wait_rises(input int n, input int bound);
    int k = 0;
    while (rises.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("rise_timeout", {31'h0, rises.size() >= n}, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int lvb_n, lvb_len, last_rd, n_rdb, n_fdb;
    logic prev_rdb, prev_lvb, fell;
    logic [31:0] cur;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_a", {16'h0, pix_a}, 0);
    chk("rst_lv_a", {31'h0, lv_a}, 0);
    chk("rst_fv_a", {31'h0, fv_a}, 0);
    chk("rst_fd_a", {31'h0, fd_a}, 0);
    chk("rst_uf_a", {31'h0, uf_a}, 0);
    chk("rst_rd_a", {31'h0, rd_a}, 0);
    chk("rst_pix_b", {16'h0, pix_b}, 0);
    chk("rst_lv_b", {31'h0, lv_b}, 0);
    rst = 0;
    for (int k = 0; k < 12; k++) exp_b.push_back(32'h0300 + k);
    go_b = 1;
    en_b = 1;
    lvb_n = 0; lvb_len = 0; last_rd = -1; n_rdb = 0; n_fdb = 0;
    prev_rdb = 0; prev_lvb = 0; fell = 0; cur = 32'hDEAD_0000;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) en_b = 0;
      if (lv_b) begin
        if (lvb_n % 4 == 0) begin
          cur = 32'hDEAD_0000;
          if (exp_b.size() > 0) cur = exp_b.pop_front();
        end
        chk("div_pixel", {16'h0, pix_b}, cur);
        lvb_n++;
        if (!fell) lvb_len++;
      end
      if (prev_lvb && !lv_b) fell = 1;
      if (rd_b) begin
        chk("div_rd_width", {31'h0, prev_rdb}, 0);
        if (n_rdb >= 1 && n_rdb <= 3) chk("div_rd_gap", k - last_rd, 4);
        last_rd = k;
        n_rdb++;
      end
      if (fd_b) n_fdb++;
      prev_rdb = rd_b;
      prev_lvb = lv_b;
    end
    chk("div_lv_len", lvb_len, 16);
    chk("div_lv_total", lvb_n, 48);
    chk("div_rd_total", n_rdb, 12);
    chk("div_fd", n_fdb, 1);
    chk("div_idle_lv", {31'h0, lv_b}, 0);
    go_b = 0;
    clr_counts();
    for (int k = 0; k < 12; k++) push(16'h0100 + 16'(k), 1);
    en_a = 1;
    run_fd(1, 60);
    repeat (4) step();
    chk("nom_lv", n_lv, 12);
    chk("nom_fv", n_fv, 18);
    chk("nom_fd", n_fd, 1);
    chk("nom_rd", n_rd, 12);
    chk("nom_uf", {31'h0, uf_a}, 0);
    chk("nom_left", exp_q.size(), 0);
    chk("nom_runs", runs.size(), 3);
    foreach (runs[i]) chk("nom_run_len", runs[i], 4);
    chk("nom_rises", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("nom_gap1", rises[1] - rises[0], 6);
      chk("nom_gap2", rises[2] - rises[1], 6);
    end
    clr_counts();
    for (int k = 0; k < 5; k++) push(16'h0200 + 16'(k), 1);
    for (int k = 0; k < 7; k++) exp_q.push_back(32'h0);
    run_fd(1, 60);
    repeat (4) step();
    chk("uf_lv", n_lv, 12);
    chk("uf_rd", n_rd, 5);
    chk("uf_left", exp_q.size(), 0);
    chk("uf_set", {31'h0, uf_a}, 1);
    repeat (5) step();
    chk("uf_sticky", {31'h0, uf_a}, 1);
    clr_a = 1;
    step();
    clr_a = 0;
    chk("uf_cleared", {31'h0, uf_a}, 0);
    clr_counts();
    push(16'h0300, 1);
    for (int k = 0; k < 11; k++) exp_q.push_back(32'h0);
    wait_rises(1, 20);
    chk("uf_pre", {31'h0, uf_a}, 0);
    clr_a = 1;
    step();
    chk("uf_set_wins", {31'h0, uf_a}, 1);
    step();
    chk("uf_set_wins2", {31'h0, uf_a}, 1);
    clr_a = 0;
    run_fd(1, 60);
    repeat (3) step();
    clr_a = 1;
    step();
    clr_a = 0;
    chk("uf_clear2", {31'h0, uf_a}, 0);
    clr_counts();
    for (int k = 0; k < 12; k++) push(16'h0400 + 16'(k), 1);
    wait_rises(2, 40);
    en_a = 0;
    run_fd(1, 60);
    for (int k = 0; k < 4; k++) push(16'h0500 + 16'(k), 0);
    repeat (20) step();
    chk("stop_lv", n_lv, 12);
    chk("stop_fd", n_fd, 1);
    chk("stop_rd", n_rd, 12);
    chk("stop_uf", {31'h0, uf_a}, 0);
    chk("stop_idle_out", {13'h0, pix_a, lv_a, fv_a, fd_a}, 0);
    chk("stop_left", exp_q.size(), 0);
    wr_p = rd_p;
    clr_counts();
    for (int k = 0; k < 12; k++) push(16'h0600 + 16'(k), 1);
    en_a = 1;
    wait_rises(1, 20);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    wr_p = rd_p;
    exp_q.delete();
    chk("rst_mid_pix", {16'h0, pix_a}, 0);
    chk("rst_mid_lv", {31'h0, lv_a}, 0);
    chk("rst_mid_fv", {31'h0, fv_a}, 0);
    chk("rst_mid_fd", {31'h0, fd_a}, 0);
    chk("rst_mid_rd", {31'h0, rd_a}, 0);
    chk("rst_mid_uf", {31'h0, uf_a}, 0);
    chk("rst_mid_nofd", n_fd, 0);
    clr_counts();
    repeat (10) step();
    chk("rst_wait_lv", n_lv, 0);
    chk("rst_wait_rd", n_rd, 0);
    for (int k = 0; k < 24; k++) push(16'h0700 + 16'(k), 1);
    run_fd(2, 120);
    repeat (30) step();
    chk("b2b_fd", n_fd, 2);
    chk("b2b_rd", n_rd, 24);
    chk("b2b_lv", n_lv, 24);
    chk("b2b_left", exp_q.size(), 0);
    chk("b2b_rises", rises.size(), 6);
    if (rises.size() >= 4) chk("b2b_period", rises[3] - rises[0], 25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
